vec_store_unit: RTL and testbench
=================================

VEC_STORE_UNIT -- requirements
Module: vec_store_unit

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning lane width in bits.
REQ-002 The module SHALL have parameter V, default 16, meaning number of lanes.
REQ-003 The module SHALL have parameter AW, default 16, meaning memory address width.
REQ-004 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The module SHALL have port start  input  1  request to store one vector, sampled only in IDLE.
REQ-007 The module SHALL have port base_addr  input  AW  byte address of lane 0, sampled with start.
REQ-008 The module SHALL have port data_in  input  [V-1:0][N-1:0]  vector ALU result, sampled with start.
REQ-009 The module SHALL have port mem_ready  input  1  memory accepts the current write this cycle.
REQ-010 The module SHALL have port mem_we  output  1  write strobe to data memory.
REQ-011 The module SHALL have port mem_addr  output  AW  write address.
REQ-012 The module SHALL have port mem_wdata  output  N  write data.
REQ-013 The module SHALL have port busy  output  1  high in STORE and DONE.
REQ-014 The module SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, STORE and DONE.
REQ-016 In IDLE with start=1, the unit SHALL register data_in and base_addr, clear the lane counter to 0, and enter STORE on the next edge.
REQ-017 In STORE, mem_addr SHALL equal (captured base + lane) modulo 2^AW, and mem_wdata SHALL equal captured lane[lane].
REQ-018 In STORE, mem_we SHALL be 1 except where masked (REQ-030).
REQ-019 A lane SHALL be consumed on a STORE-cycle edge with mem_ready=1; the lane counter SHALL increment only then.
REQ-020 While mem_ready=0, mem_we, mem_addr and mem_wdata SHALL hold stable, with no lane skipped or repeated.
REQ-021 When lane V-1 is consumed, the FSM SHALL enter DONE; done SHALL be 1 for exactly that one cycle, then the FSM SHALL return to IDLE.
REQ-022 Minimum latency from the start edge to the done cycle SHALL be V+1 cycles, plus one cycle per mem_ready=0 cycle in STORE.
REQ-023 start SHALL be ignored in STORE and DONE; captured data SHALL NOT change until the next IDLE acceptance.
REQ-024 Changes on data_in and base_addr after acceptance SHALL have no effect on the transfer in progress.
REQ-025 Address wrap: base_addr near 2^AW-1 SHALL wrap to 0 without error.
REQ-026 Outside STORE, mem_we SHALL be 0, and mem_addr and mem_wdata SHALL be 0.

Reset
REQ-027 On rst=1 at a clock edge, the FSM SHALL go to IDLE and the lane counter and captured registers SHALL clear.
REQ-028 After reset, mem_we, mem_addr, mem_wdata, busy and done SHALL all be 0.
REQ-029 Reset asserted mid-STORE SHALL abort the transfer: no further mem_we after the reset edge, no done pulse, and rst SHALL take priority over start.

Configuration
REQ-030 With VEC_STORE_MASK_EN defined:
- the port lane_mask  input  V  (bit i = write lane i) SHALL exist and be captured with start.
- a lane whose mask bit is 0 SHALL still occupy its STORE cycle with mem_we=0.
- that lane SHALL advance regardless of mem_ready, so that timing stays address-sequential.
REQ-031 Without VEC_STORE_MASK_EN, lane_mask SHALL NOT exist and every lane SHALL be written.

Verification
REQ-032 Basic store: rst, then start with base_addr=0x0100 and lane i = i+1, mem_ready=1 -> 16 consecutive writes 0x0100..0x010F with data 0x01..0x10, done pulse on cycle 17 after start, busy=0 afterwards.
REQ-033 Backpressure: same stimulus, mem_ready=0 during lanes 3 and 7 for 2 cycles each -> each address written once with stable strobe while stalled, done on cycle 21.
REQ-034 Wrap and ignored start: base_addr=0xFFFE, start re-pulsed with other data during STORE -> addresses 0xFFFE, 0xFFFF, 0x0000..0x000D, original data only, single done.
REQ-035 Reset mid-operation: rst=1 after lane 5 is written -> mem_we=0 from the next cycle, no done, and a new start then stores from lane 0.
REQ-036 Mask (VEC_STORE_MASK_EN): lane_mask=16'hAAAA, mem_ready=0 held on masked cycles -> writes only on odd lanes, done still at cycle 17.

Source files
------------

// File: rtl/vec_store_unit.sv
// rtl/vec_store_unit.sv - Serialises a captured V-lane vector into one memory write per lane (optional lane mask: VEC_STORE_MASK_EN)
module vec_store_unit #(
    parameter int N  = 8,
    parameter int V  = 16,
    parameter int AW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [V-1:0][N-1:0]   data_in,
`ifdef VEC_STORE_MASK_EN
    input  logic [V-1:0]          lane_mask,
`endif
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [N-1:0]          mem_wdata,
    output logic                  busy,
    output logic                  done
);

    localparam int LW = (V > 1) ? $clog2(V) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STORE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [LW-1:0] LAST_LANE = LW'(V - 1);

    logic [1:0]           state_q, state_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [AW-1:0]        base_q, base_d;
    logic [V-1:0][N-1:0]  data_q, data_d;
    logic                 lane_en;

`ifdef VEC_STORE_MASK_EN
    logic [V-1:0]         mask_q, mask_d;

    // Current lane is written only when its captured mask bit is set
    always_comb begin
        lane_en = mask_q[lane_q];
    end
`else
    // Every lane is written
    always_comb begin
        lane_en = 1'b1;
    end
`endif

    // Next-state: capture on accepted start, walk lanes on handshake or masked skip
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        base_d  = base_q;
        data_d  = data_q;
`ifdef VEC_STORE_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    data_d  = data_in;
`ifdef VEC_STORE_MASK_EN
                    mask_d  = lane_mask;
`endif
                    lane_d  = '0;
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                // A masked lane does not wait for memory so addresses stay sequential in time
                if (mem_ready || !lane_en) begin
                    if (lane_q == LAST_LANE) begin
                        state_d = S_DONE;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset wins over everything including start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            base_q  <= '0;
            data_q  <= '0;
`ifdef VEC_STORE_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            base_q  <= base_d;
            data_q  <= data_d;
`ifdef VEC_STORE_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    // Memory port is driven only in STORE and forced to zero elsewhere
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == S_STORE) begin
            mem_we    = lane_en;
            mem_addr  = base_q + AW'(lane_q);
            mem_wdata = data_q[lane_q];
        end
    end

    // Status outputs
    always_comb begin
        busy = (state_q == S_STORE) || (state_q == S_DONE);
        done = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_vec_store_unit.sv
// tb/tb_vec_store_unit.sv - Directed self-checking bench for vec_store_unit
module tb_vec_store_unit;

    logic               clk;
    logic               rst;
    logic               start;
    logic [15:0]        base_addr;
    logic [15:0][7:0]   data_in;
`ifdef VEC_STORE_MASK_EN
    logic [15:0]        lane_mask;
`endif
    logic               mem_ready;
    logic               mem_we;
    logic [15:0]        mem_addr;
    logic [7:0]         mem_wdata;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    vec_store_unit #(.N(8), .V(16), .AW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .data_in   (data_in),
`ifdef VEC_STORE_MASK_EN
        .lane_mask (lane_mask),
`endif
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_vec(input logic [15:0] base, input logic [7:0] first);
        base_addr = base;
        for (int i = 0; i < 16; i++) data_in[i] = first + 8'(i);
    endtask

    // Called at a negedge: start is seen by exactly one rising edge
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mem_ready = 1'b1;
        load_vec(16'h0000, 8'h00);
`ifdef VEC_STORE_MASK_EN
        lane_mask = 16'hFFFF;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata, busy, done} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_held got we=%b addr=%h data=%h busy=%b done=%b want all 0", mem_we, mem_addr, mem_wdata, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata, busy, done} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_release got we=%b addr=%h data=%h busy=%b done=%b want all 0", mem_we, mem_addr, mem_wdata, busy, done);
        end
    endtask

    task automatic test_basic();
        logic [15:0] ea;
        logic [7:0]  ed;
        load_vec(16'h0100, 8'h01);
        pulse_start();
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge clk);
            ea = (cyc <= 16) ? 16'h0100 + 16'(cyc - 1) : 16'h0000;
            ed = (cyc <= 16) ? 8'(cyc) : 8'h00;
            n_checks++;
            if (mem_we !== (cyc <= 16) || mem_addr !== ea || mem_wdata !== ed || busy !== 1'b1 || done !== (cyc == 17)) begin
                n_fail++;
                $display("FAIL basic cyc=%0d got we=%b addr=%h data=%h busy=%b done=%b want we=%b addr=%h data=%h busy=1 done=%b",
                         cyc, mem_we, mem_addr, mem_wdata, busy, done, cyc <= 16, ea, ed, cyc == 17);
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after got busy=%b done=%b we=%b want 0 0 0", busy, done, mem_we);
        end
    endtask

    task automatic test_backpressure();
        int lane = 0;
        int stalls3 = 0;
        int stalls7 = 0;
        load_vec(16'h0100, 8'h01);
        pulse_start();
        for (int cyc = 1; cyc <= 21; cyc++) begin
            @(negedge clk);
            if (lane < 16) begin
                n_checks++;
                if (mem_we !== 1'b1 || mem_addr !== 16'h0100 + 16'(lane) || mem_wdata !== 8'(lane + 1) || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_lane cyc=%0d got we=%b addr=%h data=%h done=%b want we=1 addr=%h data=%h done=0",
                             cyc, mem_we, mem_addr, mem_wdata, done, 16'h0100 + 16'(lane), 8'(lane + 1));
                end
                if (lane == 3 && stalls3 < 2) begin
                    mem_ready = 1'b0; stalls3++;
                end else if (lane == 7 && stalls7 < 2) begin
                    mem_ready = 1'b0; stalls7++;
                end else begin
                    mem_ready = 1'b1; lane++;
                end
            end else begin
                mem_ready = 1'b1;
                n_checks++;
                if (cyc !== 21 || done !== 1'b1 || mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_done cyc=%0d got done=%b we=%b want cyc=21 done=1 we=0", cyc, done, mem_we);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_after got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_wrap_ignored_start();
        logic [15:0] ea;
        int dones = 0;
        load_vec(16'hFFFE, 8'hA0);
        pulse_start();
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (cyc <= 16) begin
                ea = 16'hFFFE + 16'(cyc - 1);
                n_checks++;
                if (mem_we !== 1'b1 || mem_addr !== ea || mem_wdata !== 8'hA0 + 8'(cyc - 1)) begin
                    n_fail++;
                    $display("FAIL wrap cyc=%0d got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                             cyc, mem_we, mem_addr, mem_wdata, ea, 8'hA0 + 8'(cyc - 1));
                end
            end else if (cyc >= 18) begin
                n_checks++;
                if (busy !== 1'b0 || mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_idle cyc=%0d got busy=%b we=%b want 0 0", cyc, busy, mem_we);
                end
            end
            if (cyc == 3) begin
                load_vec(16'h1234, 8'h55);
                start = 1'b1;
            end
            if (cyc == 4) start = 1'b0;
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL wrap_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] ea;
        int stray = 0;
        load_vec(16'h0100, 8'h01);
        pulse_start();
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 16'h0100 + 16'(cyc - 1) || mem_wdata !== 8'(cyc)) begin
                n_fail++;
                $display("FAIL rstmid_pre cyc=%0d got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                         cyc, mem_we, mem_addr, mem_wdata, 16'h0100 + 16'(cyc - 1), 8'(cyc));
            end
        end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata, busy, done} !== 27'd0) begin
            n_fail++;
            $display("FAIL rstmid_abort got we=%b addr=%h data=%h busy=%b done=%b want all 0", mem_we, mem_addr, mem_wdata, busy, done);
        end
        rst = 1'b0; start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet got %0d active cycles want 0", stray);
        end
        load_vec(16'h0200, 8'h30);
        pulse_start();
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge clk);
            ea = (cyc <= 16) ? 16'h0200 + 16'(cyc - 1) : 16'h0000;
            n_checks++;
            if (mem_we !== (cyc <= 16) || mem_addr !== ea || done !== (cyc == 17) ||
                (cyc <= 16 && mem_wdata !== 8'h30 + 8'(cyc - 1))) begin
                n_fail++;
                $display("FAIL rstmid_restart cyc=%0d got we=%b addr=%h data=%h done=%b want we=%b addr=%h data=%h done=%b",
                         cyc, mem_we, mem_addr, mem_wdata, done, cyc <= 16, ea, 8'h30 + 8'(cyc - 1), cyc == 17);
            end
        end
        @(negedge clk);
    endtask

`ifdef VEC_STORE_MASK_EN
    task automatic test_mask();
        logic odd;
        load_vec(16'h0100, 8'h01);
        lane_mask = 16'hAAAA;
        pulse_start();
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge clk);
            odd = 1'(cyc - 1);
            if (cyc <= 16) begin
                n_checks++;
                if (mem_we !== odd || mem_addr !== 16'h0100 + 16'(cyc - 1) || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mask cyc=%0d got we=%b addr=%h done=%b want we=%b addr=%h done=0",
                             cyc, mem_we, mem_addr, done, odd, 16'h0100 + 16'(cyc - 1));
                end
                mem_ready = odd;
            end else begin
                mem_ready = 1'b1;
                n_checks++;
                if (done !== 1'b1 || mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mask_done got done=%b we=%b want 1 0", done, mem_we);
                end
            end
        end
        lane_mask = 16'hFFFF;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_ignored_start();
        test_reset_mid();
`ifdef VEC_STORE_MASK_EN
        test_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
